// File: rtl/spike_merge_arbiter_pkg.sv
// Shared definitions for the spike merge arbiter: barrier state encodings,
// settle default and the global neuron id width derivation.
package spike_merge_arbiter_pkg;

    typedef logic [1:0] barrier_state_t;

    localparam barrier_state_t ST_RUN    = 2'd0;
    localparam barrier_state_t ST_DRAIN  = 2'd1;
    localparam barrier_state_t ST_SETTLE = 2'd2;

    // router_busy lags a FIFO write by one cycle, so two quiet cycles are needed
    localparam int DEFAULT_SETTLE_CYCLES = 2;

    function automatic int global_id_width(input int local_w, input int num_ports);
        return local_w + $clog2(num_ports);
    endfunction

endpackage

// File: rtl/spike_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request at or after ptr,
// using the double-width subtract-and-mask trick.
module spike_rr_arbiter #(
    parameter int N      = 4,
    parameter int PORT_W = $clog2(N)
) (
    input  logic [N-1:0]      req,
    input  logic [PORT_W-1:0] ptr,
    output logic [N-1:0]      grant,
    output logic [PORT_W-1:0] grant_idx,
    output logic              any
);

    logic [2*N-1:0] w_req_dbl;
    logic [2*N-1:0] w_ptr_bit;
    logic [2*N-1:0] w_grant_dbl;

    // Subtracting the pointer bit clears the first request at or above ptr;
    // masking with the inverse isolates exactly that bit in the doubled vector.
    assign w_req_dbl   = {req, req};
    assign w_ptr_bit   = {{(2*N-1){1'b0}}, 1'b1} << ptr;
    assign w_grant_dbl = w_req_dbl & ~(w_req_dbl - w_ptr_bit);

    assign grant = w_grant_dbl[N-1:0] | w_grant_dbl[2*N-1:N];
    assign any   = |req;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_idx = i[PORT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/spike_merge_arbiter.sv
// Merges per-tile spike streams onto the router input with round-robin
// arbitration, and runs the end-of-timestep quiet barrier.
module spike_merge_arbiter
    import spike_merge_arbiter_pkg::*;
#(
    parameter int NUM_PORTS       = 4,
    parameter int LOCAL_ID_WIDTH  = 4,
    parameter int PORT_W          = $clog2(NUM_PORTS),
    parameter int GLOBAL_ID_WIDTH = global_id_width(LOCAL_ID_WIDTH, NUM_PORTS),
    parameter int SETTLE_CYCLES   = DEFAULT_SETTLE_CYCLES
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_PORTS-1:0]                s_valid,
    input  logic [NUM_PORTS*LOCAL_ID_WIDTH-1:0] s_local_id,
    output logic [NUM_PORTS-1:0]                s_ready,
    output logic                                m_valid,
    output logic [GLOBAL_ID_WIDTH-1:0]          m_neuron_id,
    input  logic                                m_ready,
    input  logic                                router_busy,
    input  logic                                step_end,
    output logic                                step_done,
    output logic                                step_overrun,
    output logic [31:0]                         merged_count
);

    localparam int QW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [PORT_W-1:0]          r_rr_ptr;
    logic                       r_m_valid;
    logic [GLOBAL_ID_WIDTH-1:0] r_m_neuron_id;
    logic [31:0]                r_merged_count;
    barrier_state_t             r_state;
    logic [QW-1:0]              r_quiet_cnt;
    logic                       r_step_done;
    logic                       r_step_overrun;

    logic [NUM_PORTS-1:0]      w_grant;
    logic [PORT_W-1:0]         w_grant_idx;
    logic                      w_any;
    logic [LOCAL_ID_WIDTH-1:0] w_local_id;
    logic                      w_load_en;
    logic                      w_accept;
    logic                      w_quiet;

    spike_rr_arbiter #(
        .N      (NUM_PORTS),
        .PORT_W (PORT_W)
    ) u_rr_arbiter (
        .req       (s_valid),
        .ptr       (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .any       (w_any)
    );

    always_comb begin
        w_local_id = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_grant[i]) begin
                w_local_id = s_local_id[i*LOCAL_ID_WIDTH +: LOCAL_ID_WIDTH];
            end
        end
    end

    // rst gates the handshake so no tile sees an accept while the block is held in reset
    assign w_load_en = !r_m_valid || m_ready;
    assign w_accept  = w_any && w_load_en && !rst;
    assign s_ready   = w_grant & {NUM_PORTS{w_load_en && !rst}};
    assign w_quiet   = !(|s_valid) && !r_m_valid && !router_busy;

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_valid     <= 1'b0;
            r_m_neuron_id <= '0;
        end else if (w_load_en) begin
            r_m_valid <= w_accept;
            if (w_accept) begin
                r_m_neuron_id <= {w_grant_idx, w_local_id};
            end
        end
    end

    // The pointer only moves on acceptance, so idle cycles keep fairness intact
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr       <= '0;
            r_merged_count <= '0;
        end else if (w_accept) begin
            r_rr_ptr       <= w_grant_idx + PORT_W'(1);
            r_merged_count <= r_merged_count + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_RUN;
            r_quiet_cnt    <= '0;
            r_step_done    <= 1'b0;
            r_step_overrun <= 1'b0;
        end else begin
            r_step_done <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (step_end) begin
                        r_state     <= ST_DRAIN;
                        r_quiet_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (step_end) begin
                        r_step_overrun <= 1'b1;
                    end
                    if (!w_quiet) begin
                        r_quiet_cnt <= '0;
                    end else if (r_quiet_cnt == QW'(SETTLE_CYCLES - 1)) begin
                        r_state     <= ST_SETTLE;
                        r_step_done <= 1'b1;
                    end else begin
                        r_quiet_cnt <= r_quiet_cnt + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    // A step_end here is not queued for the next barrier
                    if (step_end) begin
                        r_step_overrun <= 1'b1;
                    end
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign m_valid      = r_m_valid;
    assign m_neuron_id  = r_m_neuron_id;
    assign merged_count = r_merged_count;
    assign step_done    = r_step_done;
    assign step_overrun = r_step_overrun;

endmodule

// File: tb/tb_spike_merge_arbiter.sv
// Bench for spike_merge_arbiter: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_spike_merge_arbiter;

    localparam int NP     = 4;
    localparam int LW     = 4;
    localparam int SETTLE = 2;

    logic          clk;
    logic          rst;
    logic [NP-1:0] s_valid;
    logic [NP*LW-1:0] s_local_id;
    logic [NP-1:0] s_ready;
    logic          m_valid;
    logic [5:0]    m_neuron_id;
    logic          m_ready;
    logic          router_busy;
    logic          step_end;
    logic          step_done;
    logic          step_overrun;
    logic [31:0]   merged_count;

    int checks;
    int failures;

    bit          mdl_valid;
    logic [5:0]  mdl_id;
    logic [31:0] mdl_count;
    int          mdl_ptr;
    bit          mdl_waiting;
    int          mdl_quiet_run;
    bit          mdl_done;
    bit          mdl_overrun;

    spike_merge_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_local_id   (s_local_id),
        .s_ready      (s_ready),
        .m_valid      (m_valid),
        .m_neuron_id  (m_neuron_id),
        .m_ready      (m_ready),
        .router_busy  (router_busy),
        .step_end     (step_end),
        .step_done    (step_done),
        .step_overrun (step_overrun),
        .merged_count (merged_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        mdl_valid     = 1'b0;
        mdl_id        = '0;
        mdl_count     = '0;
        mdl_ptr       = 0;
        mdl_waiting   = 1'b0;
        mdl_quiet_run = 0;
        mdl_done      = 1'b0;
        mdl_overrun   = 1'b0;
    endtask

    // One clock of the reference: the spike goes to the first valid tile
    // found walking cyclically from the fairness pointer; the barrier fires
    // once SETTLE consecutive quiet cycles follow a step_end.
    task automatic cycle();
        int         gp;
        bit         load_en;
        bit         quiet;
        logic [3:0] exp_ready;
        @(negedge clk);
        load_en = !mdl_valid || m_ready;
        gp = -1;
        for (int k = 0; k < NP; k++) begin
            if (gp < 0 && s_valid[(mdl_ptr + k) % NP]) gp = (mdl_ptr + k) % NP;
        end
        exp_ready = (gp >= 0 && load_en) ? 4'(1 << gp) : 4'b0000;
        check("s_ready", 32'(s_ready), 32'(exp_ready));
        quiet = (s_valid == '0) && !mdl_valid && !router_busy;

        if (mdl_done) begin
            mdl_done = 1'b0;
            if (step_end) mdl_overrun = 1'b1;
        end else if (mdl_waiting) begin
            if (step_end) mdl_overrun = 1'b1;
            if (quiet) begin
                mdl_quiet_run++;
                if (mdl_quiet_run == SETTLE) begin
                    mdl_done    = 1'b1;
                    mdl_waiting = 1'b0;
                end
            end else begin
                mdl_quiet_run = 0;
            end
        end else if (step_end) begin
            mdl_waiting   = 1'b1;
            mdl_quiet_run = 0;
        end

        if (gp >= 0 && load_en) begin
            mdl_valid = 1'b1;
            mdl_id    = {2'(gp), s_local_id[gp*LW +: LW]};
            mdl_count = mdl_count + 32'd1;
            mdl_ptr   = (gp + 1) % NP;
        end else if (load_en) begin
            mdl_valid = 1'b0;
        end

        @(posedge clk);
        #1;
        check("m_valid", 32'(m_valid), 32'(mdl_valid));
        check("m_neuron_id", 32'(m_neuron_id), 32'(mdl_id));
        check("merged_count", merged_count, mdl_count);
        check("step_done", 32'(step_done), 32'(mdl_done));
        check("step_overrun", 32'(step_overrun), 32'(mdl_overrun));
    endtask

    initial begin
        logic [5:0] fair_ids [4];
        int         pulses;
        int         pulse_at;

        checks   = 0;
        failures = 0;
        fair_ids = '{6'h03, 6'h17, 6'h21, 6'h3F};
        mdl_reset();

        // Reset held with every tile requesting
        rst         = 1'b1;
        s_valid     = 4'b1111;
        s_local_id  = {4'd15, 4'd1, 4'd7, 4'd3};
        m_ready     = 1'b1;
        router_busy = 1'b0;
        step_end    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_count", merged_count, 32'd0);
        check("rst_step_done", 32'(step_done), 32'd0);
        rst = 1'b0;
        #1;
        check("first_grant", 32'(s_ready), 32'b0001);

        // Fairness under full load
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("fair_id", 32'(m_neuron_id), 32'(fair_ids[i % 4]));
        end
        check("fair_count", merged_count, 32'd8);

        // Backpressure holds spike 0x17
        cycle();
        cycle();
        check("bp_setup", 32'(m_neuron_id), 32'h17);
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_s_ready", 32'(s_ready), 32'd0);
            cycle();
            check("bp_hold", 32'(m_neuron_id), 32'h17);
        end
        m_ready = 1'b1;
        #1;
        check("bp_next_grant", 32'(s_ready), 32'b0100);
        cycle();
        check("bp_release", 32'(m_neuron_id), 32'h21);

        // Barrier with router_busy trailing the step_end
        s_valid = '0;
        cycle();
        step_end    = 1'b1;
        router_busy = 1'b1;
        cycle();
        step_end = 1'b0;
        repeat (3) cycle();
        router_busy = 1'b0;
        pulses   = 0;
        pulse_at = -1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (step_done) begin
                pulses++;
                pulse_at = i;
            end
        end
        check("barrier_pulses", 32'(pulses), 32'd1);
        check("barrier_delay", 32'(pulse_at), 32'd1);

        // Overrun, plus a spike during the drain restarting the quiet count
        step_end = 1'b1;
        cycle();
        step_end = 1'b0;
        cycle();
        s_valid = 4'b0001;
        cycle();
        s_valid = '0;
        cycle();
        step_end = 1'b1;
        cycle();
        step_end = 1'b0;
        check("overrun_set", 32'(step_overrun), 32'd1);
        check("restart_no_early_done", 32'(step_done), 32'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (step_done) pulses++;
        end
        check("overrun_single_done", 32'(pulses), 32'd1);

        // Asynchronous reset while a spike is stalled
        s_valid = 4'b0010;
        cycle();
        m_ready = 1'b0;
        s_valid = '0;
        cycle();
        check("pre_rst_valid", 32'(m_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        mdl_reset();
        check("async_m_valid", 32'(m_valid), 32'd0);
        check("async_count", merged_count, 32'd0);
        check("async_overrun", 32'(step_overrun), 32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        s_valid = 4'b1111;
        m_ready = 1'b1;
        #1;
        check("post_rst_ptr", 32'(s_ready), 32'b0001);
        s_valid = '0;
        step_end = 1'b1;
        cycle();
        step_end = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (step_done) pulses++;
        end
        check("post_rst_barrier", 32'(pulses), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            s_valid     = (($urandom % 3) == 0) ? 4'($urandom) : 4'b0000;
            s_local_id  = 16'($urandom);
            m_ready     = ($urandom % 4) != 0;
            router_busy = ($urandom % 5) == 0;
            step_end    = ($urandom % 12) == 0;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
